// File: rtl/game_ctrl.sv
// game_ctrl: top-level game sequencer for a one-button side-scroller.
// Walks IDLE -> PLAY -> DEAD -> OVER -> PLAY. It also decides when the bird
// hits the floor or a pipe, counts the pipes the bird has passed, and pulses
// game_rst so the bird and pipe datapaths restart.
// All outputs are registered. The current state is exported on `state` for
// observability.
module game_ctrl #(
   parameter int SCREEN_HEIGHT = 768,
   parameter int BIRD_X        = 200,
   parameter int BIRD_W        = 100,
   parameter int BIRD_H        = 100,
   parameter int PIPE_W        = 120,
   parameter int GAP_H         = 250,
   parameter int OVER_DELAY    = 100_000_000,
   parameter int SCORE_W       = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mouse_left,
   input  logic               frame_tick,
   input  logic [10:0]        bird_y,
   input  logic [10:0]        pipe_x,
   input  logic [10:0]        pipe_gap_y,
   output logic               game_rst,
   output logic               play_en,
   output logic               game_over,
   output logic [SCORE_W-1:0] score,
   output logic [1:0]         state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_DEAD = 2'd2,
      ST_OVER = 2'd3
   } state_t;

   // Geometry sums are carried at 16 bits so no 11-bit coordinate plus offset
   // can wrap.
   localparam int SW = 16;
   // The DEAD counter runs 0 .. OVER_DELAY-1.
   localparam int CW = (OVER_DELAY > 1) ? $clog2(OVER_DELAY) : 1;
   localparam logic [CW-1:0]      CNT_LAST  = CW'(OVER_DELAY - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic                 passed_q, passed_d;
   logic                 game_rst_q, game_rst_d;
   logic                 play_en_q, play_en_d;
   logic                 game_over_q, game_over_d;
   logic                 mouse_left_d_q;

   logic                 click;
   logic [SW-1:0]        bird_bot;
   logic [SW-1:0]        pipe_right;
   logic [SW-1:0]        gap_bot;
   logic                 hit_floor;
   logic                 x_overlap;
   logic                 y_outside;
   logic                 collide;
   logic                 pipe_cleared;

   // Rising edge of the button; a held button produces one click only.
   assign click = mouse_left & ~mouse_left_d_q;

   // Collision and pipe-cleared decisions from the current geometry.
   always_comb begin
      bird_bot     = SW'(bird_y) + SW'(BIRD_H);
      pipe_right   = SW'(pipe_x) + SW'(PIPE_W);
      gap_bot      = SW'(pipe_gap_y) + SW'(GAP_H);
      hit_floor    = bird_bot >= SW'(SCREEN_HEIGHT);
      x_overlap    = (SW'(pipe_x) < SW'(BIRD_X + BIRD_W)) && (pipe_right > SW'(BIRD_X));
      y_outside    = (bird_y < pipe_gap_y) || (bird_bot > gap_bot);
      collide      = hit_floor || (x_overlap && y_outside);
      pipe_cleared = pipe_right <= SW'(BIRD_X);
   end

   // Next-state and next-output logic. Outputs are derived from the next
   // state so that they line up with the registered state.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      score_d    = score_q;
      passed_d   = passed_q;
      game_rst_d = 1'b0;
      case (state_q)
         ST_IDLE, ST_OVER: begin
            // A frame_tick in the same cycle is simply not looked at here.
            if (click) begin
               state_d    = ST_PLAY;
               game_rst_d = 1'b1;
               score_d    = '0;
               passed_d   = 1'b0;
            end
         end
         ST_PLAY: begin
            if (frame_tick) begin
               if (collide) begin
                  // Collision wins: no score update on this tick.
                  state_d = ST_DEAD;
                  cnt_d   = '0;
               end else if (pipe_cleared) begin
                  if (!passed_q) begin
                     if (score_q != SCORE_MAX) begin
                        score_d = score_q + 1'b1;
                     end
                     passed_d = 1'b1;
                  end
               end else begin
                  passed_d = 1'b0;
               end
            end
         end
         ST_DEAD: begin
            // Clicks are ignored until the hold time has run out.
            if (cnt_q == CNT_LAST) begin
               state_d = ST_OVER;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      play_en_d   = (state_d == ST_PLAY);
      game_over_d = (state_d == ST_DEAD) || (state_d == ST_OVER);
   end

   // State and output registers. The button history keeps tracking during
   // reset, so a button held across reset release does not count as a click.
   always_ff @(posedge clk) begin
      mouse_left_d_q <= mouse_left;
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         score_q     <= '0;
         passed_q    <= 1'b0;
         game_rst_q  <= 1'b0;
         play_en_q   <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         score_q     <= score_d;
         passed_q    <= passed_d;
         game_rst_q  <= game_rst_d;
         play_en_q   <= play_en_d;
         game_over_q <= game_over_d;
      end
   end

   assign game_rst  = game_rst_q;
   assign play_en   = play_en_q;
   assign game_over = game_over_q;
   assign score     = score_q;
   assign state     = state_q;

endmodule
